// File: rtl/cic_pkg.sv
// Shared constants, coefficient table and FSM encoding for the
// CIC droop-compensation FIR.
package cic_pkg;

    localparam int TAPS  = 15;
    localparam int RND   = 1024;
    localparam int SHIFT = 11;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_e;

    // Symmetric 15-tap kernel, coefficients sum to 2**SHIFT.
    function automatic logic signed [11:0] coef_at(input logic [3:0] idx);
        logic signed [11:0] c;
        case (idx)
            4'd0, 4'd14: c = -12'sd8;
            4'd1, 4'd13: c = 12'sd0;
            4'd2, 4'd12: c = 12'sd36;
            4'd3, 4'd11: c = -12'sd16;
            4'd4, 4'd10: c = -12'sd120;
            4'd5, 4'd9:  c = 12'sd80;
            4'd6, 4'd8:  c = 12'sd600;
            4'd7:        c = 12'sd904;
            default:     c = 12'sd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cic_comp_sbuf.sv
// Circular sample history: one write port, read port addressed by
// distance back from the newest written sample.
module cic_comp_sbuf #(
    parameter int DIN_W = 16,
    parameter int DEPTH = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [DIN_W-1:0]        wr_data_i,
    input  logic [3:0]              rd_ofs_i,
    output logic signed [DIN_W-1:0] rd_data_o
);

    logic signed [DIN_W-1:0] mem_q [DEPTH];
    logic [3:0] wr_ptr_q;
    logic [3:0] newest;
    logic [4:0] raw;
    logic [4:0] rd_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q <= (wr_ptr_q == 4'(DEPTH - 1)) ? 4'd0
                                                    : wr_ptr_q + 4'd1;
        end
    end

    // The pointer has already advanced past the newest entry.
    assign newest  = (wr_ptr_q == 4'd0) ? 4'(DEPTH - 1)
                                        : wr_ptr_q - 4'd1;
    assign raw     = {1'b0, newest} + 5'(DEPTH) - {1'b0, rd_ofs_i};
    assign rd_addr = (raw >= 5'(DEPTH)) ? raw - 5'(DEPTH) : raw;

    assign rd_data_o = mem_q[rd_addr[3:0]];

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC 15-tap droop-compensation FIR behind cic_decimator:
// one rounded, saturated output per accepted input strobe.
module cic_comp_fir
    import cic_pkg::*;
#(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 16,
    parameter int COEF_W = 12,
    parameter int ACC_W  = 32
) (
    input  logic              cic_clk,
    input  logic              cic_rstn,
    input  logic [DIN_W-1:0]  fir_din,
    input  logic              fir_din_vld,
    output logic [DOUT_W-1:0] fir_dout,
    output logic              fir_dout_vld,
    output logic              fir_busy,
    output logic              fir_err_ovr
);

    localparam int PROD_W = DIN_W + COEF_W;

    localparam logic signed [DOUT_W-1:0] OMAX =
        {1'b0, {(DOUT_W - 1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] OMIN =
        {1'b1, {(DOUT_W - 1){1'b0}}};

    fir_state_e state_q;
    logic [3:0] tap_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [DOUT_W-1:0] dout_q;
    logic vld_q;
    logic busy_q;
    logic ovr_q;

    logic accept;
    logic signed [DIN_W-1:0] x_w;
    logic signed [COEF_W-1:0] h_w;
    logic signed [PROD_W-1:0] prod_w;
    logic signed [ACC_W-1:0] rnd_w;
    logic signed [ACC_W-1:0] shr_w;
    logic signed [DOUT_W-1:0] sat_w;

    // OUT also accepts, so strobes spaced exactly 16 cycles never drop.
    assign accept = fir_din_vld &&
                    (state_q == IDLE || state_q == OUT);

    cic_comp_sbuf #(
        .DIN_W (DIN_W),
        .DEPTH (TAPS)
    ) u_sbuf (
        .clk_i     (cic_clk),
        .rst_ni    (cic_rstn),
        .wr_en_i   (accept),
        .wr_data_i (fir_din),
        .rd_ofs_i  (tap_q),
        .rd_data_o (x_w)
    );

    assign h_w    = COEF_W'(coef_at(tap_q));
    assign prod_w = PROD_W'(x_w) * PROD_W'(h_w);
    assign acc_d  = acc_q + ACC_W'(prod_w);

    assign rnd_w = acc_q + ACC_W'(RND);
    assign shr_w = rnd_w >>> SHIFT;

    always_comb begin
        sat_w = shr_w[DOUT_W-1:0];
        if (shr_w > ACC_W'(OMAX)) begin
            sat_w = OMAX;
        end else if (shr_w < ACC_W'(OMIN)) begin
            sat_w = OMIN;
        end
    end

    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            state_q <= IDLE;
            tap_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (fir_din_vld && state_q == MAC) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (fir_din_vld) begin
                        state_q <= MAC;
                        acc_q   <= '0;
                        tap_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    tap_q <= tap_q + 4'd1;
                    if (tap_q == 4'(TAPS - 1)) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    dout_q <= sat_w;
                    vld_q  <= 1'b1;
                    if (fir_din_vld) begin
                        state_q <= MAC;
                        acc_q   <= '0;
                        tap_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fir_dout     = dout_q;
    assign fir_dout_vld = vld_q;
    assign fir_busy     = busy_q;
    assign fir_err_ovr  = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: directed stimulus pushes expected
// outputs, a negedge monitor pops and compares value and latency.
module tb_cic_comp_fir;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        din_vld;
    logic [15:0] dout;
    logic        dout_vld;
    logic        busy;
    logic        ovr;

    int n_chk;
    int n_fail;
    int cyc;
    int vld_cnt;

    int exp_q[$];
    int edge_q[$];
    int hist[15];

    int H[15]   = '{-8, 0, 36, -16, -120, 80, 600, 904,
                    600, 80, -120, -16, 36, 0, -8};
    int IMP[15] = '{-4, 0, 18, -8, -59, 39, 293, 441,
                    293, 39, -59, -8, 18, 0, -4};

    cic_comp_fir dut (
        .cic_clk      (clk),
        .cic_rstn     (rst_n),
        .fir_din      (din),
        .fir_din_vld  (din_vld),
        .fir_dout     (dout),
        .fir_dout_vld (dout_vld),
        .fir_busy     (busy),
        .fir_err_ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model();
        longint s;
        s = 0;
        for (int k = 0; k < 15; k++) begin
            s += longint'(H[k]) * longint'(hist[k]);
        end
        s = (s + 1024) >>> 11;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic push_hist(input int x);
        for (int k = 14; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 15; k++) hist[k] = 0;
    endtask

    task automatic send(input int x, input bit use_exp, input int e);
        @(negedge clk);
        din     = 16'(x);
        din_vld = 1'b1;
        push_hist(x);
        exp_q.push_back(use_exp ? e : model());
        edge_q.push_back(cyc + 1);
        @(negedge clk);
        din_vld = 1'b0;
        chk("busy_after_strobe", int'(busy), 1);
        repeat (14) @(negedge clk);
    endtask

    task automatic send_ovr(input int x, input int junk);
        @(negedge clk);
        din     = 16'(x);
        din_vld = 1'b1;
        push_hist(x);
        exp_q.push_back(model());
        edge_q.push_back(cyc + 1);
        @(negedge clk);
        din_vld = 1'b0;
        repeat (4) @(negedge clk);
        din     = 16'(junk);
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic impulse();
        send(1000, 1'b1, IMP[0]);
        for (int i = 1; i < 15; i++) send(0, 1'b1, IMP[i]);
        drain();
    endtask

    always @(negedge clk) begin
        if (rst_n && dout_vld) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got %0d, expected none",
                         $signed(dout));
            end else begin
                int e;
                int s;
                e = exp_q.pop_front();
                s = edge_q.pop_front();
                chk("dout", int'($signed(dout)), e);
                chk("latency", cyc - s, 16);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int pat;
        n_chk   = 0;
        n_fail  = 0;
        vld_cnt = 0;
        rst_n   = 1'b0;
        din     = '0;
        din_vld = 1'b0;
        clear_hist();
        repeat (3) @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_vld", int'(dout_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(ovr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        impulse();

        for (int i = 0; i < 20; i++) send(-1000, i >= 14, -1000);
        drain();

        for (int j = 0; j < 15; j++) begin
            pat = (H[j] > 0) ? 32767 : ((H[j] < 0) ? -32768 : 0);
            send(pat, j == 14, 32767);
        end
        drain();

        for (int j = 0; j < 15; j++) begin
            pat = (H[j] > 0) ? -32768 : ((H[j] < 0) ? 32767 : 0);
            send(pat, j == 14, -32768);
        end
        drain();

        cnt0 = vld_cnt;
        for (int i = 0; i < 30; i++) send(i * 1111 - 15000, 1'b0, 0);
        drain();
        chk("maxrate_count", vld_cnt - cnt0, 30);
        chk("maxrate_ovr", int'(ovr), 0);
        chk("idle_busy", int'(busy), 0);

        send_ovr(5000, 12345);
        send(-2500, 1'b0, 0);
        drain();
        chk("ovr_set", int'(ovr), 1);
        repeat (20) @(negedge clk);
        chk("ovr_sticky", int'(ovr), 1);

        @(negedge clk);
        din     = 16'(777);
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        chk("busy_before_abort", int'(busy), 1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_dout", int'(dout), 0);
        chk("abort_vld", int'(dout_vld), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ovr", int'(ovr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_hist();
        repeat (20) @(negedge clk);
        chk("abort_no_out_q", exp_q.size(), 0);

        impulse();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
